// File: rtl/nor_flash_seq_ctrl.sv
// NOR flash sequencer: turns read / program / sector-erase requests into timed flash
// bus cycles, polls the ready pin, and always restores read-array mode afterwards.
module nor_flash_seq_ctrl #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int SECTOR_BITS = 15,
  parameter int T_SETUP     = 1,
  parameter int T_WP        = 3,
  parameter int T_ACC       = 4,
  parameter int RST_CYCLES  = 8,
  parameter int TIMEOUT     = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] flash_addr,
  inout  wire  [DATA_WIDTH-1:0] flash_data,
  output logic                  flash_ce_n,
  output logic                  flash_oe_n,
  output logic                  flash_we_n,
  output logic                  flash_rst_n,
  input  logic                  flash_ready
);

  typedef enum logic [3:0] {
    S_FRST, S_IDLE, S_RD_ACC, S_WB_SETUP, S_WB_PULSE, S_WB_HOLD, S_BLANK, S_POLL, S_RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

  // Which bus write of the sequence is in flight: first command, second command/data, read-array
  localparam logic [1:0] PH_CMD1  = 2'd0;
  localparam logic [1:0] PH_CMD2  = 2'd1;
  localparam logic [1:0] PH_RDARR = 2'd2;

  localparam logic [DATA_WIDTH-1:0] CMD_PROG   = DATA_WIDTH'(16'h0040);
  localparam logic [DATA_WIDTH-1:0] CMD_ERASE1 = DATA_WIDTH'(16'h0020);
  localparam logic [DATA_WIDTH-1:0] CMD_ERASE2 = DATA_WIDTH'(16'h00D0);
  localparam logic [DATA_WIDTH-1:0] CMD_RDARR  = DATA_WIDTH'(16'h00FF);
  localparam logic [ADDR_WIDTH-1:0] SECT_MASK  = ADDR_WIDTH'((1 << SECTOR_BITS) - 1);

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [1:0]            phase_q, phase_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic [ADDR_WIDTH-1:0] bus_addr_s;
  logic [DATA_WIDTH-1:0] bus_data_s;

  logic                  ready_q, ready_d, valid_q, valid_d, rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rrdata_q, rrdata_d, dout_q, dout_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic                  ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                  frst_n_q, frst_n_d, drive_q, drive_d;

  // Next-state sequencing, then output decode from the next state so every pin is a flop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_s = '0;
    case (state_q)
      S_FRST: begin
        if (cnt_q == 32'(RST_CYCLES - 1)) begin state_d = S_IDLE; cnt_d = '0; end
        else begin cnt_d = cnt_q + 32'd1; end
      end
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          phase_d = PH_CMD1;
          case (req_op)
            OP_READ:           state_d = S_RD_ACC;
            OP_PROG, OP_ERASE: state_d = S_WB_SETUP;
            default: begin state_d = S_RESP; err_d = 1'b1; end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_ACC: begin
        if (cnt_q == 32'(T_ACC - 1)) begin state_d = S_RESP; rdata_s = flash_data; end
        else begin cnt_d = cnt_q + 32'd1; end
      end
      S_WB_SETUP: begin
        if (cnt_q == 32'(T_SETUP - 1)) begin state_d = S_WB_PULSE; cnt_d = '0; end
        else begin cnt_d = cnt_q + 32'd1; end
      end
      S_WB_PULSE: begin
        if (cnt_q == 32'(T_WP - 1)) begin state_d = S_WB_HOLD; cnt_d = '0; end
        else begin cnt_d = cnt_q + 32'd1; end
      end
      S_WB_HOLD: begin
        cnt_d = '0;
        case (phase_q)
          PH_CMD1: begin state_d = S_WB_SETUP; phase_d = PH_CMD2; end
          PH_CMD2: state_d = S_BLANK;
          default: state_d = S_RESP;
        endcase
      end
      S_BLANK: begin
        if (cnt_q == 32'd1) begin state_d = S_POLL; cnt_d = '0; end
        else begin cnt_d = cnt_q + 32'd1; end
      end
      S_POLL: begin
        if (flash_ready) begin
          state_d = S_WB_SETUP; phase_d = PH_RDARR; cnt_d = '0;
        end else if (cnt_q == 32'(TIMEOUT - 1)) begin
          state_d = S_WB_SETUP; phase_d = PH_RDARR; cnt_d = '0; err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: begin state_d = S_FRST; cnt_d = '0; end
    endcase

    bus_addr_s = ((op_d == OP_ERASE) && (phase_d != PH_RDARR)) ? (addr_d & ~SECT_MASK) : addr_d;
    case (phase_d)
      PH_CMD1: bus_data_s = (op_d == OP_PROG) ? CMD_PROG : CMD_ERASE1;
      PH_CMD2: bus_data_s = (op_d == OP_PROG) ? wdata_d : CMD_ERASE2;
      default: bus_data_s = CMD_RDARR;
    endcase

    ready_d  = 1'b0;
    valid_d  = 1'b0;
    rrdata_d = '0;
    rerr_d   = 1'b0;
    faddr_d  = faddr_q;
    dout_d   = '0;
    drive_d  = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    frst_n_d = 1'b1;
    case (state_d)
      S_FRST:   frst_n_d = 1'b0;
      S_IDLE:   ready_d = 1'b1;
      S_RD_ACC: begin ce_n_d = 1'b0; oe_n_d = 1'b0; faddr_d = addr_d; end
      S_WB_SETUP, S_WB_HOLD: begin
        ce_n_d = 1'b0; faddr_d = bus_addr_s; dout_d = bus_data_s; drive_d = 1'b1;
      end
      S_WB_PULSE: begin
        ce_n_d = 1'b0; we_n_d = 1'b0; faddr_d = bus_addr_s; dout_d = bus_data_s; drive_d = 1'b1;
      end
      S_BLANK, S_POLL: ce_n_d = 1'b0;
      S_RESP: begin valid_d = 1'b1; rrdata_d = rdata_s; rerr_d = err_d; end
      default: frst_n_d = 1'b0;
    endcase
  end

  // State, request context and all output flops; reset parks the flash bus safely
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FRST;
      cnt_q    <= '0;
      phase_q  <= PH_CMD1;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      rrdata_q <= '0;
      rerr_q   <= 1'b0;
      faddr_q  <= '0;
      dout_q   <= '0;
      drive_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      frst_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      rrdata_q <= rrdata_d;
      rerr_q   <= rerr_d;
      faddr_q  <= faddr_d;
      dout_q   <= dout_d;
      drive_q  <= drive_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      frst_n_q <= frst_n_d;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = valid_q;
  assign rsp_rdata   = rrdata_q;
  assign rsp_err     = rerr_q;
  assign flash_addr  = faddr_q;
  assign flash_ce_n  = ce_n_q;
  assign flash_oe_n  = oe_n_q;
  assign flash_we_n  = we_n_q;
  assign flash_rst_n = frst_n_q;
  assign flash_data  = drive_q ? dout_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_nor_flash_seq_ctrl.sv
// Scoreboard bench for nor_flash_seq_ctrl: a small flash model answers reads, a bus
// monitor records every write pulse, and each test task compares against queued expectations.
module tb_nor_flash_seq_ctrl;
  localparam int AW = 20, DW = 16, T_SETUP = 1, T_WP = 3, T_ACC = 4, RSTC = 8, TO = 50;
  localparam int WR_CYC = T_SETUP + T_WP + 1;
  localparam logic [1:0] OP_RD = 2'b00, OP_PG = 2'b01, OP_ER = 2'b10, OP_IL = 2'b11;

  typedef struct { logic [DW-1:0] rdata; logic err; int lat; } rsp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int len; bit chk_addr; } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, req_valid = 1'b0, flash_ready = 1'b1, probe = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, model_rdata = '0;
  wire req_ready, rsp_valid, rsp_err, flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n;
  wire [DW-1:0] rsp_rdata, flash_data;
  wire [AW-1:0] flash_addr;

  int checks = 0, failures = 0;
  int oe_low_cnt = 0, ce_low_cnt = 0, we_run = 0;
  rsp_t exp_rsp[$];
  wr_t exp_wr[$], obs_wr[$];
  wr_t cur_wr;

  nor_flash_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .flash_addr(flash_addr), .flash_data(flash_data), .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n), .flash_rst_n(flash_rst_n),
    .flash_ready(flash_ready));

  // Flash model drives the array on a read; probe drives zeros to expose any DUT driver.
  assign flash_data = probe ? {DW{1'b0}} :
                      ((flash_ce_n === 1'b0 && flash_oe_n === 1'b0) ? model_rdata : {DW{1'bz}});

  always @(negedge clk) begin
    if (flash_oe_n === 1'b0) oe_low_cnt++;
    if (flash_ce_n === 1'b0) ce_low_cnt++;
    if (flash_we_n === 1'b0) begin
      we_run++;
      cur_wr.addr = flash_addr;
      cur_wr.data = flash_data;
    end else if (we_run != 0) begin
      cur_wr.len = we_run;
      cur_wr.chk_addr = 1'b1;
      obs_wr.push_back(cur_wr);
      we_run = 0;
    end
  end

  task automatic send_req(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Returns cycles from acceptance to the rsp_valid sample, or -1 if it never came
  task automatic wait_rsp(input int ready_after, output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 300) begin
      if (lat == ready_after) flash_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (rsp_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    int low = 0, n = 0;
    rst_n = 1'b0; flash_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({req_ready, rsp_valid, rsp_err} !== 3'b000) begin failures++;
      $display("FAIL reset_hs got=%b exp=000", {req_ready, rsp_valid, rsp_err}); end
    checks++; if (rsp_rdata !== 16'h0000 || flash_addr !== 20'h00000) begin failures++;
      $display("FAIL reset_regs got=%h/%h exp=0/0", rsp_rdata, flash_addr); end
    checks++; if ({flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n} !== 4'b1110) begin failures++;
      $display("FAIL reset_ctl got=%b exp=1110", {flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n}); end
    probe = 1'b1; #1;
    checks++; if (flash_data !== 16'h0000) begin failures++;
      $display("FAIL reset_hiz got=%h exp=0000", flash_data); end
    probe = 1'b0;
    rst_n = 1'b1;
    while (req_ready !== 1'b1 && n < 30) begin
      if (flash_rst_n === 1'b0) low++;
      @(negedge clk); n++;
    end
    checks++; if (low !== RSTC) begin failures++;
      $display("FAIL frst_len got=%0d exp=%0d", low, RSTC); end
    checks++; if ({req_ready, flash_rst_n} !== 2'b11) begin failures++;
      $display("FAIL frst_exit got=%b exp=11", {req_ready, flash_rst_n}); end
  endtask

  task automatic test_read();
    int lat, oe0;
    rsp_t e;
    model_rdata = 16'hBEEF; flash_ready = 1'b1; obs_wr.delete();
    exp_rsp.push_back('{rdata: 16'hBEEF, err: 1'b0, lat: T_ACC + 1});
    oe0 = oe_low_cnt;
    send_req(OP_RD, 20'h00123, 16'h0000);
    wait_rsp(-1, lat);
    e = exp_rsp.pop_front();
    checks++; if (lat !== e.lat) begin failures++;
      $display("FAIL read_lat got=%0d exp=%0d", lat, e.lat); end
    checks++; if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin failures++;
      $display("FAIL read_rsp got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    checks++; if (oe_low_cnt - oe0 !== T_ACC) begin failures++;
      $display("FAIL read_oe got=%0d exp=%0d", oe_low_cnt - oe0, T_ACC); end
    checks++; if (flash_addr !== 20'h00123 || obs_wr.size() !== 0) begin failures++;
      $display("FAIL read_bus got=%h/%0d exp=00123/0", flash_addr, obs_wr.size()); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++;
      $display("FAIL read_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_program();
    int lat, oe0;
    rsp_t e;
    wr_t w, o;
    obs_wr.delete(); exp_wr.delete();
    exp_rsp.push_back('{rdata: 16'h0000, err: 1'b0, lat: 20 + WR_CYC + 1});
    exp_wr.push_back('{addr: 20'h00010, data: 16'h0040, len: T_WP, chk_addr: 1'b1});
    exp_wr.push_back('{addr: 20'h00010, data: 16'h1234, len: T_WP, chk_addr: 1'b1});
    exp_wr.push_back('{addr: 20'h00010, data: 16'h00FF, len: T_WP, chk_addr: 1'b1});
    oe0 = oe_low_cnt; flash_ready = 1'b0;
    send_req(OP_PG, 20'h00010, 16'h1234);
    wait_rsp(20, lat);
    e = exp_rsp.pop_front();
    checks++; if (lat !== e.lat) begin failures++;
      $display("FAIL prog_lat got=%0d exp=%0d", lat, e.lat); end
    checks++; if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin failures++;
      $display("FAIL prog_rsp got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    checks++; if (obs_wr.size() !== exp_wr.size() || oe_low_cnt !== oe0) begin failures++;
      $display("FAIL prog_nwr got=%0d/oe%0d exp=%0d/oe0", obs_wr.size(), oe_low_cnt - oe0, exp_wr.size()); end
    while (exp_wr.size() != 0 && obs_wr.size() != 0) begin
      w = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o.addr !== w.addr || o.data !== w.data || o.len !== w.len) begin failures++;
        $display("FAIL prog_wr got=%h@%h/%0d exp=%h@%h/%0d", o.data, o.addr, o.len, w.data, w.addr, w.len); end
    end
  endtask

  task automatic test_erase();
    int lat, extra = 0;
    rsp_t e;
    wr_t w, o;
    obs_wr.delete(); exp_wr.delete(); flash_ready = 1'b1;
    exp_rsp.push_back('{rdata: 16'h0000, err: 1'b0, lat: 3 * WR_CYC + 2 + 1 + 1});
    exp_wr.push_back('{addr: 20'h18000, data: 16'h0020, len: T_WP, chk_addr: 1'b1});
    exp_wr.push_back('{addr: 20'h18000, data: 16'h00D0, len: T_WP, chk_addr: 1'b1});
    exp_wr.push_back('{addr: 20'h00000, data: 16'h00FF, len: T_WP, chk_addr: 1'b0});
    send_req(OP_ER, 20'h1ABCD, 16'h0000);
    wait_rsp(-1, lat);
    e = exp_rsp.pop_front();
    checks++; if (lat !== e.lat || rsp_err !== e.err || rsp_rdata !== e.rdata) begin failures++;
      $display("FAIL erase_rsp got=%0d/%b/%h exp=%0d/%b/%h", lat, rsp_err, rsp_rdata, e.lat, e.err, e.rdata); end
    checks++; if (obs_wr.size() !== exp_wr.size()) begin failures++;
      $display("FAIL erase_nwr got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() != 0 && obs_wr.size() != 0) begin
      w = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o.data !== w.data || o.len !== w.len || (w.chk_addr && o.addr !== w.addr)) begin failures++;
        $display("FAIL erase_wr got=%h@%h/%0d exp=%h@%h/%0d", o.data, o.addr, o.len, w.data, w.addr, w.len); end
    end
    repeat (10) begin @(negedge clk); if (rsp_valid === 1'b1) extra++; end
    checks++; if (extra !== 0) begin failures++;
      $display("FAIL erase_once got=%0d exp=0", extra); end
  endtask

  task automatic test_timeout();
    int lat = 1;
    logic ce_mid = 1'b1;
    wr_t o;
    obs_wr.delete(); flash_ready = 1'b0;
    send_req(OP_PG, 20'h00200, 16'hA5A5);
    while (rsp_valid !== 1'b1 && lat < 300) begin
      if (lat == 2 * WR_CYC + 2 + TO / 2) ce_mid = flash_ce_n;
      @(negedge clk); lat++;
    end
    checks++; if (lat !== 3 * WR_CYC + 2 + TO + 1) begin failures++;
      $display("FAIL to_lat got=%0d exp=%0d", lat, 3 * WR_CYC + 2 + TO + 1); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin failures++;
      $display("FAIL to_err got=%b/%b exp=1/1", rsp_valid, rsp_err); end
    checks++; if (ce_mid !== 1'b0) begin failures++;
      $display("FAIL to_poll_ce got=%b exp=0", ce_mid); end
    o.data = 16'h0000;
    if (obs_wr.size() != 0) o = obs_wr[obs_wr.size() - 1];
    checks++; if (obs_wr.size() !== 3 || o.data !== 16'h00FF || o.addr !== 20'h00200) begin failures++;
      $display("FAIL to_rdarr got=%0d:%h@%h exp=3:00ff@00200", obs_wr.size(), o.data, o.addr); end
    flash_ready = 1'b1;
  endtask

  task automatic test_illegal();
    int lat, ce0;
    ce0 = ce_low_cnt; obs_wr.delete();
    send_req(OP_IL, 20'h00055, 16'h0000);
    wait_rsp(-1, lat);
    checks++; if (lat !== 1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0000) begin failures++;
      $display("FAIL illegal_rsp got=%0d/%b/%h exp=1/1/0000", lat, rsp_err, rsp_rdata); end
    @(negedge clk);
    checks++; if (ce_low_cnt !== ce0 || obs_wr.size() !== 0) begin failures++;
      $display("FAIL illegal_bus got=%0d/%0d exp=0/0", ce_low_cnt - ce0, obs_wr.size()); end
  endtask

  task automatic test_reset_mid_pulse();
    int n = 0;
    flash_ready = 1'b1;
    send_req(OP_PG, 20'h00ABC, 16'h5555);
    while (flash_we_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (flash_we_n !== 1'b0) begin failures++;
      $display("FAIL mid_pulse_seen got=%b exp=0", flash_we_n); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({flash_we_n, flash_ce_n, flash_rst_n, req_ready} !== 4'b1100) begin failures++;
      $display("FAIL mid_rst_ctl got=%b exp=1100", {flash_we_n, flash_ce_n, flash_rst_n, req_ready}); end
    probe = 1'b1; #1;
    checks++; if (flash_data !== 16'h0000) begin failures++;
      $display("FAIL mid_rst_hiz got=%h exp=0000", flash_data); end
    probe = 1'b0;
    @(negedge clk); rst_n = 1'b1; n = 0;
    while (req_ready !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    checks++; if (req_ready !== 1'b1) begin failures++;
      $display("FAIL mid_recover got=%b exp=1", req_ready); end
    obs_wr.delete();
  endtask

  task automatic test_back_to_back();
    int lat;
    rsp_t e;
    model_rdata = 16'h5A5A;
    exp_rsp.push_back('{rdata: 16'h5A5A, err: 1'b0, lat: T_ACC + 1});
    exp_rsp.push_back('{rdata: 16'h0000, err: 1'b1, lat: 1});
    exp_rsp.push_back('{rdata: 16'h5A5A, err: 1'b0, lat: T_ACC + 1});
    for (int i = 0; i < 3; i++) begin
      send_req((i == 1) ? OP_IL : OP_RD, 20'hFFFFF, 16'h0000);
      wait_rsp(-1, lat);
      e = exp_rsp.pop_front();
      checks++; if (lat !== e.lat || rsp_rdata !== e.rdata || rsp_err !== e.err) begin failures++;
        $display("FAIL b2b_%0d got=%0d/%h/%b exp=%0d/%h/%b", i, lat, rsp_rdata, rsp_err, e.lat, e.rdata, e.err); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_program();
    test_erase();
    test_timeout();
    test_illegal();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
